// File: rtl/fixed_point_pkg.sv
// Fixed-point constants and control state encoding shared by the FFT-datapath
// arithmetic units (Goldschmidt divider and shift-add multiplier).
package fixed_point_pkg;

    localparam int unsigned Q_WIDTH = 24;
    localparam int unsigned Q_FRAC  = 23;

    localparam logic [Q_WIDTH-1:0] Q_ONE = 24'h800000;
    localparam logic [Q_WIDTH-1:0] Q_MAX = 24'hFFFFFF;

    typedef enum logic {
        IDLE,
        RUN
    } q_state_e;

endpackage

// File: rtl/goldsmith_mul.sv
// Sequential radix-2 shift-add Q1.23 unsigned multiplier: truncating, saturating,
// one result per WIDTH+1 enabled cycles with a start/res_ready handshake.
module goldsmith_mul
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = Q_WIDTH,
    parameter int unsigned FRAC  = Q_FRAC
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product,
    output logic             res_ready,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    q_state_e           state;
    q_state_e           state_nxt;
    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   b_sh;
    logic [CNT_W-1:0]   count;
    logic               last;
    logic               sat;

    // The final partial product must be folded in on the completing edge, so
    // the result is taken from the combinational sum rather than acc.
    always_comb begin
        acc_sum = acc + (b_sh[0] ? a_sh : '0);
        last    = (state == RUN) && (count == CNT_W'(WIDTH - 1));
        sat     = |acc_sum[2*WIDTH-1:FRAC+WIDTH];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            count     <= '0;
            product   <= '0;
            overflow  <= 1'b0;
            res_ready <= 1'b1;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh      <= {{WIDTH{1'b0}}, multiplicand};
                        b_sh      <= multiplier;
                        acc       <= '0;
                        count     <= '0;
                        res_ready <= 1'b0;
                    end
                end
                RUN: begin
                    acc   <= acc_sum;
                    a_sh  <= a_sh << 1;
                    b_sh  <= b_sh >> 1;
                    count <= count + 1'b1;
                    if (last) begin
                        product   <= sat ? '1 : acc_sum[FRAC+WIDTH-1:FRAC];
                        overflow  <= sat;
                        res_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_goldsmith_mul.sv
// Self-checking bench for goldsmith_mul: directed cases from the test plan plus
// randomized operands against an arithmetic reference model.
module tb_goldsmith_mul;

    localparam int unsigned W = 24;
    localparam int unsigned F = 23;

    logic         clk = 1'b0;
    logic         n_reset = 1'b0;
    logic         clk_en = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] multiplicand = '0;
    logic [W-1:0] multiplier = '0;
    logic [W-1:0] product;
    logic         res_ready;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    goldsmith_mul #(.WIDTH(W), .FRAC(F)) dut (
        .clk(clk),
        .n_reset(n_reset),
        .clk_en(clk_en),
        .start(start),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .product(product),
        .res_ready(res_ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: exact product, truncated to Q1.23, saturated at >= 2.0.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] p, output logic ovf);
        longint unsigned full;
        longint unsigned q;
        full = longint'(a) * longint'(b);
        q    = full >> F;
        ovf  = (q >= (64'd1 << W));
        p    = ovf ? {W{1'b1}} : q[W-1:0];
    endfunction

    // Runs one operation: start pulse, optional clk_en stall window and an
    // optional start pulse while busy. cyc = enabled+disabled edges until ready.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall_at, input int stall_len, input int busy_at,
                         output int cyc, output logic held_ok);
        logic [W-1:0] p0;
        logic         o0;
        @(negedge clk);
        p0 = product;
        o0 = overflow;
        held_ok = 1'b1;
        multiplicand = a;
        multiplier = b;
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc == busy_at);
            multiplicand = W'($urandom);
            multiplier = W'($urandom);
            clk_en = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (!res_ready && (product !== p0 || overflow !== o0)) held_ok = 1'b0;
        end while (!res_ready && cyc < 300);
        start = 1'b0;
        clk_en = 1'b1;
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        #12;
        n_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (product !== '0 || res_ready !== 1'b1 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: product=%h ready=%b ovf=%b, want 000000/1/0",
                         i, product, res_ready, overflow);
            end
        end
    endtask

    task automatic test_one;
        int cyc;
        logic ok;
        do_op(24'h800000, 24'h800000, 0, 0, -1, cyc, ok);
        checks++;
        if (cyc !== 25) begin
            errors++;
            $display("FAIL one_latency: got %0d edges, want 25", cyc);
        end
        checks++;
        if (product !== 24'h800000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL one_product: got %h ovf=%b, want 800000 ovf=0", product, overflow);
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL one_hold: outputs changed while busy");
        end
    endtask

    task automatic test_small;
        int cyc;
        logic ok;
        do_op(24'h400000, 24'h400000, 0, 0, -1, cyc, ok);
        checks++;
        if (product !== 24'h200000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL quarter: got %h ovf=%b, want 200000 ovf=0", product, overflow);
        end
        do_op(24'h000001, 24'h000001, 0, 0, -1, cyc, ok);
        checks++;
        if (product !== 24'h000000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL lsb_trunc: got %h ovf=%b, want 000000 ovf=0", product, overflow);
        end
    endtask

    task automatic test_overflow;
        int cyc;
        logic ok;
        do_op(24'hFFFFFF, 24'hFFFFFF, 0, 0, -1, cyc, ok);
        checks++;
        if (product !== 24'hFFFFFF || overflow !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got %h ovf=%b, want FFFFFF ovf=1", product, overflow);
        end
        do_op(24'h800000, 24'h000000, 0, 0, -1, cyc, ok);
        checks++;
        if (product !== 24'h000000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %h ovf=%b, want 000000 ovf=0", product, overflow);
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: saturated result not held while busy");
        end
    endtask

    task automatic test_stall_busy;
        int cyc;
        logic ok;
        logic [W-1:0] p1;
        do_op(24'h600000, 24'h600000, 5, 7, 10, cyc, ok);
        checks++;
        if (cyc !== 32) begin
            errors++;
            $display("FAIL stall_latency: got %0d edges, want 32", cyc);
        end
        checks++;
        if (product !== 24'h480000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL stall_product: got %h ovf=%b, want 480000 ovf=0", product, overflow);
        end
        p1 = product;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_ready !== 1'b1 || product !== p1) break;
        end
        checks++;
        if (res_ready !== 1'b1 || product !== p1) begin
            errors++;
            $display("FAIL busy_start_ignored: ready=%b product=%h, want 1 and %h",
                     res_ready, product, p1);
        end
    endtask

    task automatic test_async_reset;
        int cyc;
        logic ok;
        @(negedge clk);
        multiplicand = 24'h800000;
        multiplier = 24'h400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_reset = 1'b0;
        #1;
        checks++;
        if (product !== '0 || res_ready !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: product=%h ready=%b ovf=%b, want 000000/1/0",
                     product, res_ready, overflow);
        end
        @(negedge clk);
        n_reset = 1'b1;
        do_op(24'h800000, 24'h400000, 0, 0, -1, cyc, ok);
        checks++;
        if (product !== 24'h400000 || overflow !== 1'b0 || cyc !== 25) begin
            errors++;
            $display("FAIL after_reset: got %h ovf=%b in %0d edges, want 400000 ovf=0 in 25",
                     product, overflow, cyc);
        end
    endtask

    task automatic test_random;
        int cyc;
        int sl;
        logic ok;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ep;
        logic eo;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i % 4 == 1) a = a >> $urandom_range(1, 12);
            if (i % 4 == 2) b = b >> $urandom_range(1, 12);
            sl = (i % 3 == 0) ? $urandom_range(1, 6) : 0;
            model(a, b, ep, eo);
            do_op(a, b, $urandom_range(2, 20), sl, $urandom_range(2, 20), cyc, ok);
            checks++;
            if (product !== ep || overflow !== eo || cyc !== 25 + sl || ok !== 1'b1) begin
                errors++;
                $display("FAIL random %0d %h*%h: got %h ovf=%b %0d edges held=%b, want %h ovf=%b %0d edges",
                         i, a, b, product, overflow, cyc, ok, ep, eo, 25 + sl);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a[5];
        logic [W-1:0] b[5];
        logic [W-1:0] ep;
        logic eo;
        int cyc;
        for (int i = 0; i < 5; i++) begin
            a[i] = W'($urandom);
            b[i] = W'($urandom);
        end
        b[1] = b[1] >> 4;
        @(negedge clk);
        multiplicand = a[0];
        multiplier = b[0];
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!res_ready && cyc < 100);
            model(a[i], b[i], ep, eo);
            checks++;
            if (cyc !== 25 || product !== ep || overflow !== eo) begin
                errors++;
                $display("FAIL b2b %0d: got %h ovf=%b in %0d edges, want %h ovf=%b in 25",
                         i, product, overflow, cyc, ep, eo);
            end
            if (i < 4) begin
                multiplicand = a[i+1];
                multiplier = b[i+1];
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_one();
        test_small();
        test_overflow();
        test_stall_busy();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/goldsmith_mul.md
Name: goldsmith_mul

Overview:
- Sequential radix-2 shift-add fixed-point multiplier, unsigned Q1.23 (1.0 = 0x800000). It is the inverse-direction companion to the Goldschmidt divider in the FFT datapath.
- Computes product = (multiplicand * multiplier) >> FRAC with truncation and saturation.
- Used for twiddle scaling, and by the bench to re-multiply quotient by divisor as a divider cross-check.
- Same start/res_ready handshake style as the divider: one result per WIDTH+1 enabled cycles.

Parameters:
- WIDTH, 24, operand and result width in bits.
- FRAC, 23, fractional bits; the product is right-shifted by FRAC.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- clk_en  in  1  synchronous enable; when 0, all state is frozen. No clock gating inside this block.
- start  in  1  request; sampled only when res_ready=1 and clk_en=1.
- multiplicand  in  WIDTH  operand A, Q1.23 unsigned.
- multiplier  in  WIDTH  operand B, Q1.23 unsigned.
- product  out  WIDTH  registered result, Q1.23.
- res_ready  out  1  1 = idle and product valid; 0 = busy.
- overflow  out  1  registered; set with product when the result saturated.

Behaviour:
- Reset (async assert, any state, including mid-operation): state=IDLE, product=0, res_ready=1, overflow=0, acc=0, count=0. The in-flight operation is discarded.
- States: IDLE, RUN.
- IDLE:
  - On an enabled edge with start=1: capture A into a 2*WIDTH-bit shift register (zero-extended), B into a WIDTH-bit shift register, acc=0, count=0, res_ready<=0, go to RUN.
  - start=0 keeps IDLE; product and overflow hold.
- RUN, each enabled edge:
  - If B[0]=1: acc += A.
  - Then A <<= 1, B >>= 1, count += 1.
- Completion: on the enabled edge where count reaches WIDTH-1 (the WIDTH-th RUN edge), the final accumulation is included.
  - full = final acc, 2*WIDTH bits.
  - product <= full[FRAC+WIDTH-1:FRAC].
  - overflow <= OR of full[2*WIDTH-1:FRAC+WIDTH].
  - If overflow: product <= all ones.
  - res_ready<=1, go to IDLE.
- Latency: the start-capture edge plus WIDTH RUN edges, so res_ready is high after WIDTH+1 enabled edges (25 at default).
- Back-to-back: start held high gives a new capture on the edge after res_ready rises, i.e. one result every WIDTH+1 enabled edges.
- start while busy is ignored and not queued. Operand inputs are ignored except at the capture edge.
- product and overflow are stable while busy (they hold the previous result) and change only at completion.
- clk_en=0 freezes state, counters and outputs, stretching latency by the number of disabled cycles.
- Rounding is truncation toward zero, matching the divider. No rounding bias.
- Overflow condition: the true product is ≥ 2.0 in Q1.23.

Decomposition:
- Shared package fixed_point_pkg:
  - Q_WIDTH=24, Q_FRAC=23.
  - Q_ONE=24'h800000, Q_MAX=24'hFFFFFF.
  - State enum {IDLE, RUN}.
  - Shared with the divider.
- No sub-module. Control and the shift-add datapath fit naturally in one module.

Test Plan:
- Reset, then hold start=0 for 10 cycles -> product=0x000000, res_ready=1, overflow=0 throughout.
- A=0x800000, B=0x800000, start pulse -> res_ready low for exactly 25 cycles, then product=0x800000, overflow=0.
- A=0x400000, B=0x400000 -> product=0x200000. Then A=0x000001, B=0x000001 -> product=0x000000 (truncated), overflow=0.
- A=0xFFFFFF, B=0xFFFFFF -> product=0xFFFFFF, overflow=1. Next op A=0x800000, B=0x000000 -> product=0, overflow=0.
- Start 0x600000×0x600000, deassert clk_en for 7 cycles mid-RUN -> completion at 32 cycles, product=0x480000. Start pulsed while busy -> ignored, no second result.
- Start 0x800000×0x400000, assert n_reset=0 at RUN cycle 10 -> immediately product=0, res_ready=1. A fresh op afterwards gives the correct product 0x400000.
